// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and load/store.
// Data side wins by default; a streak guard forces a fetch grant; stalled accesses time out.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MAX_STREAK = 4,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_valid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_valid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              resp_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              err_sticky
);
    localparam int unsigned SW = $clog2(MAX_STREAK + 1);
    localparam int unsigned WW = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);
    localparam logic [WW-1:0] WAIT_LAST  = WW'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StFetch, StData, StResp} state_t;

    state_t            r_state, w_state_nxt;
    logic              w_done, w_timeout;
    logic [SW-1:0]     r_streak, w_streak;
    logic [WW-1:0]     r_wait, w_wait;
    logic              r_mem_req, w_mem_req;
    logic              r_mem_we, w_mem_we;
    logic [ADDR_W-1:0] r_mem_addr, w_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata;
    logic              r_i_valid, w_i_valid;
    logic              r_d_valid, w_d_valid;
    logic [DATA_W-1:0] r_i_rdata, w_i_rdata;
    logic [DATA_W-1:0] r_d_rdata, w_d_rdata;
    logic              r_resp_err, w_resp_err;
    logic              r_err_sticky, w_err_sticky;

    always_ff @(posedge clk) begin
        if (reset) r_state <= StIdle;
        else       r_state <= w_state_nxt;
    end

    // Completion is checked before the timeout so a late mem_ready still wins.
    always_comb begin
        w_state_nxt = r_state;
        w_done      = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            StIdle: begin
                if (d_req && (!i_req || (r_streak < STREAK_MAX))) w_state_nxt = StData;
                else if (i_req)                                     w_state_nxt = StFetch;
            end
            StFetch, StData: begin
                if (mem_ready) begin
                    w_done      = 1'b1;
                    w_state_nxt = StResp;
                end else if (r_wait == WAIT_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = StResp;
                end
            end
            StResp:  w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    always_comb begin
        w_streak     = r_streak;
        w_wait       = r_wait;
        w_mem_we     = r_mem_we;
        w_mem_addr   = r_mem_addr;
        w_mem_wdata  = r_mem_wdata;
        w_i_rdata    = r_i_rdata;
        w_d_rdata    = r_d_rdata;
        w_err_sticky = r_err_sticky;
        w_i_valid    = 1'b0;
        w_d_valid    = 1'b0;
        w_resp_err   = 1'b0;
        w_mem_req    = (w_state_nxt == StFetch) || (w_state_nxt == StData);

        if ((r_state == StIdle) && (w_state_nxt == StData)) begin
            w_mem_we    = d_we;
            w_mem_addr  = {d_addr[ADDR_W-1:2], 2'b00};
            w_mem_wdata = d_wdata;
            if (!i_req)                       w_streak = '0;
            else if (r_streak != STREAK_MAX)  w_streak = r_streak + 1'b1;
        end else if ((r_state == StIdle) && (w_state_nxt == StFetch)) begin
            w_mem_we    = 1'b0;
            w_mem_addr  = {i_addr[ADDR_W-1:2], 2'b00};
            w_mem_wdata = '0;
            w_streak    = '0;
        end

        if ((r_state == StFetch) || (r_state == StData)) begin
            w_wait = (w_done || w_timeout) ? '0 : r_wait + 1'b1;
        end

        if (w_done || w_timeout) begin
            w_mem_we   = 1'b0;
            w_resp_err = w_timeout;
            if (w_timeout) w_err_sticky = 1'b1;
            if (r_state == StData) begin
                w_d_valid = 1'b1;
                w_d_rdata = (w_done && !r_mem_we) ? mem_rdata : '0;
            end else begin
                w_i_valid = 1'b1;
                w_i_rdata = w_done ? mem_rdata : '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_streak     <= '0;
            r_wait       <= '0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_i_valid    <= 1'b0;
            r_d_valid    <= 1'b0;
            r_i_rdata    <= '0;
            r_d_rdata    <= '0;
            r_resp_err   <= 1'b0;
            r_err_sticky <= 1'b0;
        end else begin
            r_streak     <= w_streak;
            r_wait       <= w_wait;
            r_mem_req    <= w_mem_req;
            r_mem_we     <= w_mem_we;
            r_mem_addr   <= w_mem_addr;
            r_mem_wdata  <= w_mem_wdata;
            r_i_valid    <= w_i_valid;
            r_d_valid    <= w_d_valid;
            r_i_rdata    <= w_i_rdata;
            r_d_rdata    <= w_d_rdata;
            r_resp_err   <= w_resp_err;
            r_err_sticky <= w_err_sticky;
        end
    end

    assign mem_req    = r_mem_req;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign i_valid    = r_i_valid;
    assign d_valid    = r_d_valid;
    assign i_rdata    = r_i_rdata;
    assign d_rdata    = r_d_rdata;
    assign resp_err   = r_resp_err;
    assign err_sticky = r_err_sticky;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by randomized traffic,
// predicted by a transaction-level model of grant priority, latency and timeout.
module tb_mem_port_arbiter;
    localparam int MAXS = 4;
    localparam int TMO  = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic        i_valid;
    logic [31:0] i_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_valid;
    logic [31:0] d_rdata;
    logic        resp_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        err_sticky;

    mem_port_arbiter #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .MAX_STREAK(MAXS),
        .TIMEOUT   (TMO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_valid   (i_valid),
        .i_rdata   (i_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_valid   (d_valid),
        .d_rdata   (d_rdata),
        .resp_err  (resp_err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .err_sticky(err_sticky)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit i_pend = 1'b0;
    bit d_pend = 1'b0;
    int dstreak = 0;      // data grants in a row that made a waiting fetch wait longer
    bit sticky_m = 1'b0;
    bit last_was_data = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_reqs();
        i_req = i_pend;
        d_req = d_pend;
    endtask

    task automatic raise_fetch(input logic [31:0] a);
        i_pend = 1'b1;
        i_addr = a;
    endtask

    task automatic raise_data(input logic we, input logic [31:0] a, input logic [31:0] wd);
        d_pend  = 1'b1;
        d_we    = we;
        d_addr  = a;
        d_wdata = wd;
    endtask

    // Called at a negedge while the DUT idles; memory stays unready for 'delay' cycles.
    task automatic run_access(input int delay, input logic [31:0] rd);
        bit          exp_data, exp_err, seen;
        logic        exp_we;
        logic [31:0] exp_addr, exp_wdata, exp_rdata;
        int          done_k, k, reqcyc, bad;
        drive_reqs();
        exp_data = d_pend && (!i_pend || (dstreak < MAXS));
        if (exp_data) begin
            exp_we    = d_we;
            exp_addr  = {d_addr[31:2], 2'b00};
            exp_wdata = d_wdata;
            dstreak   = i_pend ? ((dstreak < MAXS) ? dstreak + 1 : MAXS) : 0;
        end else begin
            exp_we    = 1'b0;
            exp_addr  = {i_addr[31:2], 2'b00};
            exp_wdata = '0;
            dstreak   = 0;
        end
        exp_err   = (delay >= TMO);
        done_k    = exp_err ? TMO - 1 : delay;
        exp_rdata = (exp_err || exp_we) ? 32'h0 : rd;
        sticky_m  = sticky_m | exp_err;

        @(negedge clk);
        check("grant_addr", mem_addr, exp_addr);
        check("grant_we", 32'(mem_we), 32'(exp_we));
        if (exp_we) check("grant_wdata", mem_wdata, exp_wdata);
        k = 0; reqcyc = 0; bad = 0; seen = 1'b0;
        while (!seen && (k <= TMO + 2)) begin
            if (i_valid || d_valid) seen = 1'b1;
            else begin
                if (mem_req) reqcyc++;
                if (mem_we !== exp_we || mem_addr !== exp_addr) bad++;
                if (exp_we && (mem_wdata !== exp_wdata)) bad++;
                mem_ready = (k == delay);
                mem_rdata = (k == delay) ? rd : $urandom;
                k++;
                @(negedge clk);
            end
        end
        mem_ready = 1'b0;
        check("resp_seen", 32'(seen), 32'd1);
        check("req_cycles", 32'(reqcyc), 32'(done_k + 1));
        check("latency", 32'(k), 32'(done_k + 1));
        check("hold_during_access", 32'(bad), 32'd0);
        check("i_valid", 32'(i_valid), 32'(!exp_data));
        check("d_valid", 32'(d_valid), 32'(exp_data));
        check("rdata", exp_data ? d_rdata : i_rdata, exp_rdata);
        check("resp_err", 32'(resp_err), 32'(exp_err));
        check("err_sticky", 32'(err_sticky), 32'(sticky_m));
        check("resp_mem_req", 32'(mem_req), 32'd0);
        last_was_data = d_valid;
        if (exp_data) d_pend = 1'b0;
        else          i_pend = 1'b0;
        drive_reqs();
        @(negedge clk);
        check("idle_valid", 32'({i_valid, d_valid}), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bit exp_ord [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

        repeat (3) @(negedge clk);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_valids", 32'({i_valid, d_valid, resp_err}), 32'd0);
        check("rst_sticky", 32'(err_sticky), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Lone fetch with an unaligned address, memory ready at once.
        raise_fetch(32'h0000_0106);
        run_access(0, 32'h0013_0313);

        // Store with three wait states.
        raise_data(1'b1, 32'h0000_0040, 32'hDEAD_BEEF);
        run_access(3, 32'h5555_AAAA);

        // Timeout, then the sticky flag survives idle cycles.
        raise_data(1'b0, 32'h0000_0080, 32'h0);
        run_access(100, 32'h1111_2222);
        repeat (3) @(negedge clk);
        check("sticky_hold", 32'(err_sticky), 32'd1);

        // Completion on the timeout cycle wins, for both sides.
        raise_data(1'b0, 32'h0000_0084, 32'h0);
        run_access(TMO - 1, 32'h1234_5678);
        raise_fetch(32'h0000_0300);
        run_access(TMO - 1, 32'h8765_4321);

        // Reset in the middle of a stalled data access.
        raise_data(1'b0, 32'h0000_0200, 32'h0);
        drive_reqs();
        @(negedge clk);
        check("mid_data_mem_req", 32'(mem_req), 32'd1);
        @(negedge clk);
        reset  = 1'b1;
        d_pend = 1'b0;
        drive_reqs();
        repeat (3) @(negedge clk);
        check("rst2_mem_req", 32'(mem_req), 32'd0);
        check("rst2_valids", 32'({i_valid, d_valid}), 32'd0);
        check("rst2_sticky", 32'(err_sticky), 32'd0);
        reset    = 1'b0;
        sticky_m = 1'b0;
        dstreak  = 0;
        @(negedge clk);
        check("post_rst_idle", 32'(mem_req), 32'd0);

        // Sustained contention: starvation guard lets fetch through every fifth grant.
        raise_fetch(32'h0000_1000);
        raise_data(1'b0, 32'h0000_2000, 32'h0);
        for (int n = 0; n < 10; n++) begin
            run_access(0, $urandom);
            check("contention_order", 32'(last_was_data), 32'(exp_ord[n]));
            if (!i_pend) raise_fetch($urandom);
            if (!d_pend) raise_data(1'($urandom_range(0, 1)), $urandom, $urandom);
        end
        i_pend = 1'b0;
        d_pend = 1'b0;
        drive_reqs();
        @(negedge clk);
        dstreak = 0;

        // Randomized traffic including occasional timeouts and races.
        for (int n = 0; n < 40; n++) begin
            if (!i_pend && ($urandom_range(0, 1) != 0)) raise_fetch($urandom);
            if (!d_pend && ($urandom_range(0, 2) != 0))
                raise_data(1'($urandom_range(0, 1)), $urandom, $urandom);
            if (!i_pend && !d_pend) begin
                drive_reqs();
                repeat (2) @(negedge clk);
                check("idle_no_req", 32'(mem_req), 32'd0);
            end else begin
                run_access(int'($urandom_range(0, TMO + 2)), $urandom);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
